// File: rtl/instr_encoder.sv
// instr_encoder
// Packs symbolic MIPS-subset instructions (addu, subu, ori, lw, sw, beq, j,
// lui) into 32-bit words. Each word is held in a single-entry output register
// and streamed to instruction memory. The memory word address auto-increments
// from BASE_ADDR and wraps; the written-word count saturates the input at DEPTH.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_EMPTY   | output register free, no write presented
// ST_PENDING | encoded word presented on wr_*, waiting for wr_ready
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  // Symbolic operation codes on in_op
  localparam logic [3:0] OP_ADDU = 4'd0;
  localparam logic [3:0] OP_SUBU = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_SW   = 4'd4;
  localparam logic [3:0] OP_BEQ  = 4'd5;
  localparam logic [3:0] OP_J    = 4'd6;
  localparam logic [3:0] OP_LUI  = 4'd7;

  // MIPS primary opcodes and R-type function codes
  localparam logic [5:0] MIPS_RTYPE = 6'b000000;
  localparam logic [5:0] MIPS_ORI   = 6'b001101;
  localparam logic [5:0] MIPS_LW    = 6'b100011;
  localparam logic [5:0] MIPS_SW    = 6'b101011;
  localparam logic [5:0] MIPS_BEQ   = 6'b000100;
  localparam logic [5:0] MIPS_J     = 6'b000010;
  localparam logic [5:0] MIPS_LUI   = 6'b001111;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;

  // Capacity in count width, and in one extra bit so count + pending cannot overflow
  localparam logic [ADDR_W:0]   DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W+1:0] DEPTH_X  = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  state_t              r_state;
  logic [31:0]         r_data;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_err;

  logic [31:0]         w_enc;
  logic                w_legal;
  logic                w_pending;
  logic                w_done;
  logic                w_room;
  logic                w_ready;
  logic                w_accept;
  logic [ADDR_W+1:0]   w_occupancy;

  // Field packing for the supported subset; unused fields are dropped
  always_comb begin
    w_enc   = '0;
    w_legal = 1'b1;
    case (in_op)
      OP_ADDU: w_enc = {MIPS_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FUNCT_ADDU};
      OP_SUBU: w_enc = {MIPS_RTYPE, in_rs, in_rt, in_rd, 5'b00000, FUNCT_SUBU};
      OP_ORI:  w_enc = {MIPS_ORI, in_rs, in_rt, in_imm};
      OP_LW:   w_enc = {MIPS_LW, in_rs, in_rt, in_imm};
      OP_SW:   w_enc = {MIPS_SW, in_rs, in_rt, in_imm};
      OP_BEQ:  w_enc = {MIPS_BEQ, in_rs, in_rt, in_imm};
      OP_J:    w_enc = {MIPS_J, in_target};
      OP_LUI:  w_enc = {MIPS_LUI, 5'b00000, in_rt, in_imm};
      default: w_legal = 1'b0;
    endcase
  end

  // Handshake: a slot is free when empty or the pending word leaves this cycle,
  // and the words already written plus the one in flight must stay below DEPTH
  always_comb begin
    w_pending   = (r_state == ST_PENDING);
    w_done      = w_pending && wr_ready;
    w_occupancy = {1'b0, r_count} + {{(ADDR_W+1){1'b0}}, w_pending};
    w_room      = (w_occupancy < DEPTH_X);
    w_ready     = !start && (!w_pending || wr_ready) && w_room;
    w_accept    = in_valid && w_ready;
  end

  // Output register FSM with address, count and sticky error tracking; start
  // overrides every other event, including a completion on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
      r_err   <= 1'b0;
    end else if (start) begin
      r_state <= ST_EMPTY;
      r_count <= '0;
      r_addr  <= BASE_ADDR;
      r_err   <= 1'b0;
    end else begin
      if (w_done) begin
        r_count <= r_count + CNT_ONE;
        r_addr  <= r_addr + ADDR_ONE;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            if (w_legal) begin
              r_state <= ST_PENDING;
              r_data  <= w_enc;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ST_PENDING: begin
          if (w_accept && w_legal) begin
            r_data <= w_enc;
          end else if (w_done) begin
            r_state <= ST_EMPTY;
          end
          if (w_accept && !w_legal) begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Outputs straight from state registers
  always_comb begin
    in_ready = w_ready;
    wr_en    = w_pending;
    wr_addr  = r_addr;
    wr_data  = r_data;
    count    = r_count;
    full     = (r_count == DEPTH_C);
    err      = r_err;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed program/backpressure/illegal/start/reset
// scenarios on a default instance, a wrap/full scenario on a small instance
// (ADDR_W=2, BASE_ADDR=3), and a randomized run against a transaction model.
module tb_instr_encoder;

  logic clk;
  logic rst_n;

  // default instance (ADDR_W=10, BASE_ADDR=0)
  logic        start, in_valid, in_ready, wr_en, wr_ready, full, err;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [10:0] count;

  // small instance (ADDR_W=2, BASE_ADDR=3)
  logic        s_start, s_valid, s_in_ready, s_wr_en, s_wr_ready, s_full, s_err;
  logic [3:0]  s_op;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [15:0] s_imm;
  logic [25:0] s_target;
  logic [1:0]  s_wr_addr;
  logic [31:0] s_wr_data;
  logic [2:0]  s_count;

  int n_tests = 0;
  int n_fail  = 0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .count(count), .full(full), .err(err)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_in_ready),
    .in_op(s_op), .in_rs(s_rs), .in_rt(s_rt), .in_rd(s_rd), .in_imm(s_imm),
    .in_target(s_target), .wr_en(s_wr_en), .wr_ready(s_wr_ready), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .count(s_count), .full(s_full), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding built from the MIPS field layout with plain arithmetic
  function automatic logic [31:0] ref_encode(input logic [3:0] op, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    int unsigned urs, urt, urd, uimm, utgt, w;
    urs = rs; urt = rt; urd = rd; uimm = imm; utgt = tgt;
    case (op)
      4'd0:    w = urs * 2097152 + urt * 65536 + urd * 2048 + 33;
      4'd1:    w = urs * 2097152 + urt * 65536 + urd * 2048 + 35;
      4'd2:    w = 13 * 67108864 + urs * 2097152 + urt * 65536 + uimm;
      4'd3:    w = 35 * 67108864 + urs * 2097152 + urt * 65536 + uimm;
      4'd4:    w = 43 * 67108864 + urs * 2097152 + urt * 65536 + uimm;
      4'd5:    w = 4 * 67108864 + urs * 2097152 + urt * 65536 + uimm;
      4'd6:    w = 2 * 67108864 + utgt;
      default: w = 15 * 67108864 + urt * 65536 + uimm;
    endcase
    return w;
  endfunction

  task automatic drv(input logic v, input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt, input logic wrr, input logic st);
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_target = tgt; wr_ready = wrr; start = st;
  endtask

  task automatic idle(input logic wrr);
    drv(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, wrr, 1'b0);
  endtask

  task automatic restart();
    drv(1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 1'b1);
    @(negedge clk);
    idle(1'b0);
  endtask

  task automatic test_reset();
    #1;
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_tests++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_tests++; if (wr_addr !== 10'd0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
    n_tests++; if (count !== 11'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_tests++; if (s_wr_addr !== 2'd3) begin n_fail++; $display("FAIL reset_small_addr: got %0d want 3", s_wr_addr); end
  endtask

  task automatic test_program();
    logic [3:0]  p_op  [7];
    logic [4:0]  p_rs  [7];
    logic [4:0]  p_rt  [7];
    logic [4:0]  p_rd  [7];
    logic [15:0] p_imm [7];
    logic [25:0] p_tgt [7];
    logic [31:0] p_exp [7];
    for (int k = 0; k < 7; k++) begin
      p_rs[k] = 5'($urandom); p_rt[k] = 5'($urandom); p_rd[k] = 5'($urandom);
      p_imm[k] = 16'($urandom); p_tgt[k] = 26'($urandom);
    end
    p_op[0] = 4'd0; p_rs[0] = 5'd1;  p_rt[0] = 5'd2; p_rd[0] = 5'd3;       p_exp[0] = 32'h00221821;
    p_op[1] = 4'd2; p_rs[1] = 5'd0;  p_rt[1] = 5'd8; p_imm[1] = 16'h1234;  p_exp[1] = 32'h34081234;
    p_op[2] = 4'd3; p_rs[2] = 5'd29; p_rt[2] = 5'd4; p_imm[2] = 16'd8;     p_exp[2] = 32'h8FA40008;
    p_op[3] = 4'd4; p_rs[3] = 5'd29; p_rt[3] = 5'd5; p_imm[3] = 16'd4;     p_exp[3] = 32'hAFA50004;
    p_op[4] = 4'd5; p_rs[4] = 5'd1;  p_rt[4] = 5'd2; p_imm[4] = 16'hFFFF;  p_exp[4] = 32'h1022FFFF;
    p_op[5] = 4'd6; p_tgt[5] = 26'h100;                                    p_exp[5] = 32'h08000100;
    p_op[6] = 4'd7; p_rt[6] = 5'd9;  p_imm[6] = 16'hABCD;                  p_exp[6] = 32'h3C09ABCD;
    restart();
    for (int i = 0; i < 8; i++) begin
      if (i < 7) drv(1'b1, p_op[i], p_rs[i], p_rt[i], p_rd[i], p_imm[i], p_tgt[i], 1'b1, 1'b0);
      else idle(1'b1);
      #1;
      if (i < 7) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL prog_ready[%0d]: got %b want 1", i, in_ready); end
      end
      if (i > 0) begin
        n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL prog_wr_en[%0d]: got %b want 1", i-1, wr_en); end
        n_tests++; if (wr_data !== p_exp[i-1]) begin n_fail++; $display("FAIL prog_data[%0d]: got %h want %h", i-1, wr_data, p_exp[i-1]); end
        n_tests++; if (wr_addr !== 10'(i-1)) begin n_fail++; $display("FAIL prog_addr[%0d]: got %0d want %0d", i-1, wr_addr, i-1); end
        n_tests++; if (count !== 11'(i-1)) begin n_fail++; $display("FAIL prog_count[%0d]: got %0d want %0d", i-1, count, i-1); end
      end
      @(negedge clk);
    end
    idle(1'b1);
    #1;
    n_tests++; if (count !== 11'd7) begin n_fail++; $display("FAIL prog_final_count: got %0d want 7", count); end
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL prog_final_wr_en: got %b want 0", wr_en); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    restart();
    drv(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'($urandom), 26'($urandom), 1'b0, 1'b0);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b want 1", in_ready); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 4'd2, 5'd0, 5'd8, 5'($urandom), 16'h1234, 26'($urandom), 1'b0, 1'b0);
      #1;
      n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL bp_wr_en[%0d]: got %b want 1", i, wr_en); end
      n_tests++; if (wr_data !== 32'h00221821) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want 00221821", i, wr_data); end
      n_tests++; if (wr_addr !== 10'd0) begin n_fail++; $display("FAIL bp_addr[%0d]: got %0d want 0", i, wr_addr); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); end
      @(negedge clk);
    end
    drv(1'b1, 4'd2, 5'd0, 5'd8, 5'($urandom), 16'h1234, 26'($urandom), 1'b1, 1'b0);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    idle(1'b1);
    #1;
    n_tests++; if (count !== 11'd1) begin n_fail++; $display("FAIL bp_count1: got %0d want 1", count); end
    n_tests++; if (wr_data !== 32'h34081234) begin n_fail++; $display("FAIL bp_next_data: got %h want 34081234", wr_data); end
    n_tests++; if (wr_addr !== 10'd1) begin n_fail++; $display("FAIL bp_next_addr: got %0d want 1", wr_addr); end
    @(negedge clk);
    idle(1'b1);
    #1;
    n_tests++; if (count !== 11'd2) begin n_fail++; $display("FAIL bp_count2: got %0d want 2", count); end
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", wr_en); end
    @(negedge clk);
  endtask

  task automatic test_illegal();
    restart();
    drv(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b1, 4'd9, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom), 1'b1, 1'b0);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ready: got %b want 1", in_ready); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ill_err_before: got %b want 0", err); end
    @(negedge clk);
    drv(1'b1, 4'd2, 5'd0, 5'd8, 5'd0, 16'h1234, 26'd0, 1'b1, 1'b0);
    #1;
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err_set: got %b want 1", err); end
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL ill_no_write: got %b want 0", wr_en); end
    n_tests++; if (count !== 11'd1) begin n_fail++; $display("FAIL ill_count: got %0d want 1", count); end
    @(negedge clk);
    idle(1'b1);
    #1;
    n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL ill_next_wr_en: got %b want 1", wr_en); end
    n_tests++; if (wr_addr !== 10'd1) begin n_fail++; $display("FAIL ill_next_addr: got %0d want 1", wr_addr); end
    n_tests++; if (wr_data !== 32'h34081234) begin n_fail++; $display("FAIL ill_next_data: got %h want 34081234", wr_data); end
    @(negedge clk);
    idle(1'b1);
    #1;
    n_tests++; if (count !== 11'd2) begin n_fail++; $display("FAIL ill_final_count: got %0d want 2", count); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_sticky: got %b want 1", err); end
    @(negedge clk);
  endtask

  task automatic test_start_pending();
    restart();
    drv(1'b1, 4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0, 1'b0);
    @(negedge clk);
    drv(1'b1, 4'd7, 5'd0, 5'd9, 5'd0, 16'hABCD, 26'd0, 1'b0, 1'b0);
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL st_pre_ready: got %b want 1", in_ready); end
    @(negedge clk);
    drv(1'b1, 4'd2, 5'd0, 5'd8, 5'd0, 16'h1234, 26'd0, 1'b1, 1'b1);
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL st_ready_low: got %b want 0", in_ready); end
    n_tests++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL st_pending: got %b want 1", wr_en); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL st_err_pre: got %b want 1", err); end
    @(negedge clk);
    idle(1'b1);
    #1;
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL st_dropped: got %b want 0", wr_en); end
    n_tests++; if (count !== 11'd0) begin n_fail++; $display("FAIL st_count: got %0d want 0", count); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL st_err_clr: got %b want 0", err); end
    @(negedge clk);
    drv(1'b1, 4'd2, 5'd0, 5'd8, 5'd0, 16'h1234, 26'd0, 1'b1, 1'b0);
    @(negedge clk);
    idle(1'b1);
    #1;
    n_tests++; if (wr_addr !== 10'd0) begin n_fail++; $display("FAIL st_next_addr: got %0d want 0", wr_addr); end
    n_tests++; if (wr_data !== 32'h34081234) begin n_fail++; $display("FAIL st_next_data: got %h want 34081234", wr_data); end
    @(negedge clk);
    idle(1'b1);
    #1;
    n_tests++; if (count !== 11'd1) begin n_fail++; $display("FAIL st_final_count: got %0d want 1", count); end
    @(negedge clk);
  endtask

  task automatic test_small_wrap();
    logic [31:0] s_exp [8];
    logic [1:0]  exp_addr;
    s_start = 1'b1; s_valid = 1'b0; s_wr_ready = 1'b0;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_wr_ready = 1'b1;
      s_op = 4'($urandom_range(0, 7)); s_rs = 5'($urandom); s_rt = 5'($urandom); s_rd = 5'($urandom);
      s_imm = 16'($urandom); s_target = 26'($urandom);
      s_exp[i] = ref_encode(s_op, s_rs, s_rt, s_rd, s_imm, s_target);
      #1;
      n_tests++; if (s_in_ready !== (i < 4)) begin n_fail++; $display("FAIL small_ready[%0d]: got %b want %b", i, s_in_ready, (i < 4)); end
      if (i >= 1 && i <= 4) begin
        exp_addr = 2'((3 + i - 1) % 4);
        n_tests++; if (s_wr_en !== 1'b1) begin n_fail++; $display("FAIL small_wr_en[%0d]: got %b want 1", i, s_wr_en); end
        n_tests++; if (s_wr_addr !== exp_addr) begin n_fail++; $display("FAIL small_addr[%0d]: got %0d want %0d", i, s_wr_addr, exp_addr); end
        n_tests++; if (s_wr_data !== s_exp[i-1]) begin n_fail++; $display("FAIL small_data[%0d]: got %h want %h", i, s_wr_data, s_exp[i-1]); end
      end
      if (i >= 5) begin
        n_tests++; if (s_wr_en !== 1'b0) begin n_fail++; $display("FAIL small_extra_write[%0d]: got %b want 0", i, s_wr_en); end
        n_tests++; if (s_full !== 1'b1) begin n_fail++; $display("FAIL small_full[%0d]: got %b want 1", i, s_full); end
        n_tests++; if (s_count !== 3'd4) begin n_fail++; $display("FAIL small_count[%0d]: got %0d want 4", i, s_count); end
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_random();
    logic        v, wrr, st, exp_ready;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    bit          m_pend, m_err;
    int unsigned m_cnt;
    logic [31:0] m_word;
    restart();
    m_pend = 0; m_err = 0; m_cnt = 0; m_word = '0;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      op  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      imm = 16'($urandom); tgt = 26'($urandom);
      wrr = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 39) == 0);
      drv(v, op, rs, rt, rd, imm, tgt, wrr, st);
      #1;
      exp_ready = !st && (!m_pend || wrr) && (m_cnt + (m_pend ? 1 : 0) < 1024);
      n_tests++; if (in_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", c, in_ready, exp_ready); end
      n_tests++; if (wr_en !== m_pend) begin n_fail++; $display("FAIL rnd_wr_en@%0d: got %b want %b", c, wr_en, m_pend); end
      n_tests++; if (count !== 11'(m_cnt)) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, count, m_cnt); end
      n_tests++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", c, err, m_err); end
      if (m_pend) begin
        n_tests++; if (wr_data !== m_word) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", c, wr_data, m_word); end
        n_tests++; if (wr_addr !== 10'(m_cnt % 1024)) begin n_fail++; $display("FAIL rnd_addr@%0d: got %0d want %0d", c, wr_addr, m_cnt % 1024); end
      end
      if (st) begin
        m_cnt = 0; m_pend = 0; m_err = 0;
      end else begin
        if (m_pend && wrr) begin
          m_cnt++;
          m_pend = 0;
        end
        if (v && exp_ready) begin
          if (op < 8) begin
            m_pend = 1;
            m_word = ref_encode(op, rs, rt, rd, imm, tgt);
          end else begin
            m_err = 1;
          end
        end
      end
      @(negedge clk);
    end
    idle(1'b0);
  endtask

  task automatic test_async_reset();
    restart();
    drv(1'b1, 4'd12, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, 1'b0);
    @(negedge clk);
    drv(1'b1, 4'd2, 5'd0, 5'd8, 5'd0, 16'h1234, 26'd0, 1'b1, 1'b0);
    @(negedge clk);
    idle(1'b0);
    #1;
    n_tests++; if (count !== 11'd1 || wr_en !== 1'b1 || err !== 1'b1)
      begin n_fail++; $display("FAIL ar_pre: got count %0d wr_en %b err %b want 1 1 1", count, wr_en, err); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL ar_wr_en: got %b want 0", wr_en); end
    n_tests++; if (wr_data !== 32'h0) begin n_fail++; $display("FAIL ar_wr_data: got %h want 0", wr_data); end
    n_tests++; if (wr_addr !== 10'd0) begin n_fail++; $display("FAIL ar_wr_addr: got %0d want 0", wr_addr); end
    n_tests++; if (count !== 11'd0) begin n_fail++; $display("FAIL ar_count: got %0d want 0", count); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ar_err: got %b want 0", err); end
    n_tests++; if (full !== 1'b0) begin n_fail++; $display("FAIL ar_full: got %b want 0", full); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    n_tests++; if (s_full !== 1'b0 || s_count !== 3'd0 || s_wr_addr !== 2'd3)
      begin n_fail++; $display("FAIL ar_small: got full %b count %0d addr %0d want 0 0 3", s_full, s_count, s_wr_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b0);
    s_start = 1'b0; s_valid = 1'b0; s_wr_ready = 1'b0; s_op = 4'd0;
    s_rs = 5'd0; s_rt = 5'd0; s_rd = 5'd0; s_imm = 16'd0; s_target = 26'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    @(negedge clk);
    test_program();
    test_backpressure();
    test_illegal();
    test_start_pending();
    test_small_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
